// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   typedef logic [15:0] halfword_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT       = 2'd1,
      WAIT_STALE = 2'd2
   } fetch_state_t;

   localparam logic [1:0] INSTR_LEN_32 = 2'b11;

endpackage

// File: rtl/instr_fetch_aligner.sv
// Fetch front end: word-aligned memory reads, parcel alignment, one instruction per handshake.
// Optional feature macro: RV_COMPRESSED_EN (16-bit parcel alignment; otherwise whole-word buffer).
module instr_fetch_aligner
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   fetch_state_t state_q, state_d;
   logic         mem_req_q, mem_req_d;
   logic [31:0]  mem_addr_q, mem_addr_d;
   logic [31:0]  faddr_q, faddr_d;
   logic [31:0]  pc_q, pc_d;
   logic         room;
   logic         fire;
   logic         rsp_live;
   logic [31:0]  redir_faddr;

   assign redir_faddr = {redirect_pc[31:2], 2'b00};
   assign fire        = instr_valid & instr_ready;
   // Only a live (non-stale) response may touch the buffer; redirect overrides it.
   assign rsp_live    = (state_q == WAIT) && mem_rvalid && !redirect_valid;

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign instr_pc = pc_q;

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      faddr_d    = faddr_q;
      if (redirect_valid) begin
         faddr_d = redir_faddr;
         case (state_q)
            WAIT: state_d = WAIT_STALE;
            WAIT_STALE: begin
               if (mem_rvalid) begin
                  state_d    = WAIT;
                  mem_req_d  = 1'b1;
                  mem_addr_d = redir_faddr;
               end
            end
            default: begin
               state_d    = WAIT;
               mem_req_d  = 1'b1;
               mem_addr_d = redir_faddr;
            end
         endcase
      end else begin
         case (state_q)
            WAIT: begin
               if (mem_rvalid) begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
                  faddr_d   = faddr_q + 32'd4;
               end
            end
            WAIT_STALE: begin
               // Stale data is dropped; the replacement request goes out right away.
               if (mem_rvalid) begin
                  state_d    = WAIT;
                  mem_req_d  = 1'b1;
                  mem_addr_d = faddr_q;
               end
            end
            default: begin
               if (room) begin
                  state_d    = WAIT;
                  mem_req_d  = 1'b1;
                  mem_addr_d = faddr_q;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= {RESET_PC[31:2], 2'b00};
         faddr_q    <= {RESET_PC[31:2], 2'b00};
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         faddr_q    <= faddr_d;
      end
   end

`ifdef RV_COMPRESSED_EN
   halfword_t [2:0] pbuf_q, pbuf_d;
   halfword_t [2:0] sh;
   logic [1:0]      cnt_q, cnt_d;
   logic [2:0]      n;
   logic            skip_q, skip_d;
   logic            is32;
   logic            unused_pc_bit;

   assign unused_pc_bit = redirect_pc[0];
   assign is32          = (pbuf_q[0][1:0] == INSTR_LEN_32);
   assign instr_valid   = is32 ? (cnt_q >= 2'd2) : (cnt_q != 2'd0);
   assign instr_out     = is32 ? {pbuf_q[1], pbuf_q[0]} : {16'h0000, pbuf_q[0]};
   assign room          = (cnt_q <= 2'd1);

   always_comb begin
      pbuf_d = pbuf_q;
      cnt_d  = cnt_q;
      pc_d   = pc_q;
      skip_d = skip_q;
      sh     = pbuf_q;
      n      = {1'b0, cnt_q};
      if (redirect_valid) begin
         cnt_d  = 2'd0;
         pc_d   = {redirect_pc[31:1], 1'b0};
         skip_d = redirect_pc[1];
      end else begin
         if (fire) begin
            if (is32) begin
               sh[0] = pbuf_q[2];
               n     = n - 3'd2;
               pc_d  = pc_q + 32'd4;
            end else begin
               sh[0] = pbuf_q[1];
               sh[1] = pbuf_q[2];
               n     = n - 3'd1;
               pc_d  = pc_q + 32'd2;
            end
         end
         // Append lands behind whatever survived this cycle's consume.
         if (rsp_live) begin
            for (int i = 0; i < 3; i++) begin
               if (3'(i) == n)
                  sh[i] = skip_q ? mem_rdata[31:16] : mem_rdata[15:0];
               else if ((3'(i) == n + 3'd1) && !skip_q)
                  sh[i] = mem_rdata[31:16];
            end
            n      = n + (skip_q ? 3'd1 : 3'd2);
            skip_d = 1'b0;
         end
         pbuf_d = sh;
         cnt_d  = n[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pbuf_q <= '0;
         cnt_q  <= 2'd0;
         skip_q <= RESET_PC[1];
         pc_q   <= {RESET_PC[31:1], 1'b0};
      end else begin
         pbuf_q <= pbuf_d;
         cnt_q  <= cnt_d;
         skip_q <= skip_d;
         pc_q   <= pc_d;
      end
   end
`else
   logic [31:0] word_q, word_d;
   logic        full_q, full_d;
   logic [1:0]  unused_pc_bits;

   assign unused_pc_bits = redirect_pc[1:0];
   assign instr_valid    = full_q;
   assign instr_out      = word_q;
   assign room           = !full_q || fire;

   always_comb begin
      word_d = word_q;
      full_d = full_q;
      pc_d   = pc_q;
      if (redirect_valid) begin
         full_d = 1'b0;
         pc_d   = redir_faddr;
      end else begin
         if (fire) begin
            full_d = 1'b0;
            pc_d   = pc_q + 32'd4;
         end
         if (rsp_live) begin
            word_d = mem_rdata;
            full_d = 1'b1;
         end
      end
   end

   // Whole-word mode only ever sits on word boundaries.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q <= 32'h0;
         full_q <= 1'b0;
         pc_q   <= {RESET_PC[31:2], 2'b00};
      end else begin
         word_q <= word_d;
         full_q <= full_d;
         pc_q   <= pc_d;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// Directed bench for instr_fetch_aligner; covers both RV_COMPRESSED_EN builds.
module tb_instr_fetch_aligner;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   int   nvec = 0;
   int   nfail = 0;
   vec_t tbl [0:15];
   int   ntbl;

   logic [31:0] mem [0:255];
   bit          hold = 1'b0;
   int          waitc = 0;

   instr_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_out      (instr_out),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Memory responder: one-cycle response pulse, blocked while hold is set.
   always @(negedge clk) begin
      if (mem_rvalid) begin
         mem_rvalid = 1'b0;
         waitc      = 0;
      end else if (mem_req && !hold) begin
         waitc = waitc + 1;
         if (waitc >= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[mem_addr[9:2]];
         end
      end else begin
         waitc = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0003 | (32'(i) << 8);
   endtask

   task automatic do_reset(input bit chk_rst);
      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (chk_rst) begin
         chk("rst.mem_req", {31'h0, mem_req}, 32'h0);
         chk("rst.mem_addr", mem_addr, 32'h0);
         chk("rst.instr_valid", {31'h0, instr_valid}, 32'h0);
         chk("rst.instr_out", instr_out, 32'h0);
         chk("rst.instr_pc", instr_pc, 32'h0);
      end
      rst_n = 1'b1;
   endtask

   task automatic wait_req(input string nm);
      int t = 0;
      @(negedge clk);
      while (!mem_req && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk(nm, {31'h0, mem_req}, 32'h1);
   endtask

   // Called on a falling edge; returns on the falling edge after the handshake.
   task automatic take(input string nm, input logic [31:0] ei, input logic [31:0] ep);
      int t = 0;
      while (!instr_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!instr_valid) begin
         nvec++;
         nfail++;
         $display("FAIL %s: timeout, instr_valid=0 want 1", nm);
      end else begin
         chk({nm, ".instr"}, instr_out, ei);
         chk({nm, ".pc"}, instr_pc, ep);
         instr_ready = 1'b1;
         @(posedge clk);
         #1 instr_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic run_table(input string nm);
      for (int i = 0; i < ntbl; i++)
         take($sformatf("%s[%0d]", nm, i), tbl[i].instr, tbl[i].pc);
   endtask

   task automatic first_req();
      chk("req.pre", {31'h0, mem_req}, 32'h0);
      @(negedge clk);
      chk("req.first", {31'h0, mem_req}, 32'h1);
      chk("req.addr", mem_addr, 32'h0);
   endtask

`ifdef RV_COMPRESSED_EN
   function automatic logic [15:0] parc(input int k);
      return 16'((k << 2) | 1);
   endfunction

   initial begin
      // Single 32-bit instruction
      clear_mem();
      mem[0] = 32'h00A0_0093;
      do_reset(1'b1);
      first_req();
      take("w32", 32'h00A0_0093, 32'h0);

      // Two compressed parcels in one word
      clear_mem();
      mem[0] = 32'h0001_4501;
      do_reset(1'b0);
      tbl[0] = '{32'h0000_4501, 32'h0};
      tbl[1] = '{32'h0000_0001, 32'h2};
      ntbl = 2;
      run_table("c16x2");

      // 32-bit instruction straddling a word boundary
      clear_mem();
      mem[0] = 32'h0093_4501;
      mem[1] = 32'h0000_00A0;
      do_reset(1'b0);
      tbl[0] = '{32'h0000_4501, 32'h0};
      tbl[1] = '{32'h00A0_0093, 32'h2};
      ntbl = 2;
      run_table("straddle");

      // Redirect to 0x102 with the 0x8 request outstanding
      clear_mem();
      mem[0]  = 32'h00A0_0093;
      mem[1]  = 32'h00B0_0093;
      mem[2]  = 32'h00C0_0093;
      mem[64] = 32'h4501_0093;
      mem[65] = 32'h0000_0001;
      do_reset(1'b0);
      take("redir.pre0", 32'h00A0_0093, 32'h0);
      take("redir.pre1", 32'h00B0_0093, 32'h4);
      hold = 1'b1;
      wait_req("redir.req");
      chk("redir.req_addr", mem_addr, 32'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0102;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      hold = 1'b0;
      @(negedge clk);
      chk("redir.flush", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
      chk("redir.new_req", {31'h0, mem_req}, 32'h1);
      chk("redir.new_addr", mem_addr, 32'h100);
      chk("redir.drop", {31'h0, instr_valid}, 32'h0);
      take("redir.hi", 32'h0000_4501, 32'h102);
      take("redir.next", 32'h0000_0001, 32'h104);

      // Back-pressure with compressed-only code
      clear_mem();
      for (int i = 0; i < 8; i++) mem[i] = {parc(2 * i + 1), parc(2 * i)};
      do_reset(1'b0);
      take("bp.p0", {16'h0, parc(0)}, 32'h0);
      repeat (10) @(negedge clk);
      chk("bp.req_low", {31'h0, mem_req}, 32'h0);
      chk("bp.valid", {31'h0, instr_valid}, 32'h1);
      chk("bp.head", instr_out, {16'h0, parc(1)});
      ntbl = 0;
      for (int k = 1; k < 8; k++) begin
         tbl[ntbl] = '{{16'h0, parc(k)}, 32'(2 * k)};
         ntbl++;
      end
      run_table("bp");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
`else
   initial begin
      // Sequential whole-word fetch
      clear_mem();
      mem[0] = 32'h00A0_0093;
      mem[1] = 32'h0000_4501;
      do_reset(1'b1);
      first_req();
      tbl[0] = '{32'h00A0_0093, 32'h0};
      tbl[1] = '{32'h0000_4501, 32'h4};
      tbl[2] = '{mem[2], 32'h8};
      tbl[3] = '{mem[3], 32'hC};
      ntbl = 4;
      run_table("seq");

      // Redirect during an outstanding request, target wraps past 0xFFFF_FFFC
      hold = 1'b1;
      do_reset(1'b0);
      wait_req("wrap.req");
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      hold = 1'b0;
      @(negedge clk);
      chk("wrap.flush", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
      chk("wrap.new_req", {31'h0, mem_req}, 32'h1);
      chk("wrap.new_addr", mem_addr, 32'hFFFF_FFFC);
      chk("wrap.drop", {31'h0, instr_valid}, 32'h0);
      take("wrap.top", mem[255], 32'hFFFF_FFFC);
      take("wrap.zero", 32'h00A0_0093, 32'h0);

      // Back-pressure: full buffer stops fetching
      do_reset(1'b0);
      repeat (12) @(negedge clk);
      chk("bp.req_low", {31'h0, mem_req}, 32'h0);
      chk("bp.valid", {31'h0, instr_valid}, 32'h1);
      chk("bp.head", instr_out, 32'h00A0_0093);
      tbl[0] = '{32'h00A0_0093, 32'h0};
      tbl[1] = '{32'h0000_4501, 32'h4};
      tbl[2] = '{mem[2], 32'h8};
      ntbl = 3;
      run_table("bp");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
`endif

endmodule
